param_core: RTL and testbench
=============================

PARAM_CORE -- requirements
Module: param_core

Interface
REQ-001 Parameter DATA_W, default 4, width of registers A, B, O and the ALU datapath.
REQ-002 Parameter PC_W, default 4, program-counter width; program space is 2^PC_W instructions.
REQ-003 Parameter IMM_W, default 4, immediate field width; legal only if PC_W <= IMM_W <= DATA_W; instruction width INST_W = IMM_W+4.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 run  input  1  execute enable; low = stall, no architectural state changes.
REQ-007 imem_addr  output  PC_W  instruction address, combinationally equal to pc.
REQ-008 imem_inst  input  INST_W  instruction word, combinational read of imem_addr, consumed same cycle.
REQ-009 out_o  output  DATA_W  register O contents.
REQ-010 out_valid  output  1  one-cycle pulse, high the cycle after O is written.
REQ-011 halted  output  1  high while FSM is in HALT.

Function
REQ-012 Fields: opc = imem_inst[INST_W-1:INST_W-3]; dst = imem_inst[INST_W-4] (0=A, 1=B); imm = imem_inst[IMM_W-1:0]; remaining bits ignored.
REQ-013 Opcodes: 000 MOVI dst<=zero-extended imm; 001 ADD dst<=A+B; 010 SUB dst<=A-B; 011 OUT O<=A; 100 JMP; 101 JC; 110 JZ; 111 HALT.
REQ-014 One instruction executes per clk cycle when FSM=RUN and run=1; single-cycle latency, no pipeline.
REQ-015 Next pc: JMP, or JC with carry=1, or JZ with zero=1 -> imm[PC_W-1:0]; HALT -> pc unchanged; otherwise pc+1 modulo 2^PC_W (PC_W'(2^PC_W-1) wraps to 0).
REQ-016 ADD: result modulo 2^DATA_W; carry<=carry-out of DATA_W-bit add.
REQ-017 SUB: result modulo 2^DATA_W; carry<=1 if A<B (borrow), else 0.
REQ-018 zero<=1 if ADD/SUB result is 0, else 0; carry and zero are registered and change only on ADD/SUB.
REQ-019 Conditional jumps test flag values registered before the current instruction.
REQ-020 ADD/SUB read A, B values from before the edge; dst writeback visible next cycle.
REQ-021 out_valid=1 exactly the cycle after an executed OUT; 0 otherwise, including stall cycles.
REQ-022 FSM states RUN, HALT; RUN->HALT on executed HALT opcode; HALT exits only via reset; in HALT pc, A, B, O, flags hold.
REQ-023 run=0 in RUN: pc, registers, flags, FSM hold; out_valid=0; a pending out_valid pulse still completes.

Reset
REQ-024 On rising clk with resetn=0: pc=0, A=B=O=0, carry=0, zero=0, FSM=RUN, out_valid=0, halted=0.
REQ-025 Reset overrides run and HALT state; instruction on imem_inst during reset cycle is not executed.
REQ-026 First instruction executed is address 0, in the first cycle with resetn=1 and run=1.

Configuration
REQ-027 Macro PARAM_CORE_HALT_EN defined: opcode 111 is HALT per REQ-022, halted output driven by FSM.
REQ-028 PARAM_CORE_HALT_EN undefined: opcode 111 is NOP (pc+1, no state change), no HALT state, halted tied 0.

Verification
REQ-029 Defaults: MOVI A,5; MOVI B,3; ADD A; OUT -> out_o=8, out_valid high exactly cycle 5, carry=0.
REQ-030 MOVI A,9; MOVI B,9; ADD A; JC 0 -> A=2, carry=1, imem_addr=0 next cycle.
REQ-031 MOVI A,3; MOVI B,3; SUB A; JC 7; JZ 9 -> zero=1, carry=0, JC falls through to addr 4, JZ loads pc=9.
REQ-032 16 MOVI instructions from pc=0 -> imem_addr 15 then 0; run held low 3 cycles mid-stream -> pc, A frozen, no out_valid.
REQ-033 HALT at addr 2 (macro defined) -> halted=1 next cycle, pc stays 2; resetn low one cycle -> pc=0, halted=0; macro undefined -> pc advances to 3.

Source files
------------

// File: rtl/param_core.sv
// Minimal accumulator-style core: 2 GPRs (A, B), output register O, carry/zero flags.
// Optional HALT opcode/state enabled by defining PARAM_CORE_HALT_EN; otherwise opcode 111 is a NOP.
module param_core #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4,
  parameter int IMM_W  = 4,
  localparam int INST_W = IMM_W + 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic [DATA_W-1:0] out_o,
  output logic              out_valid,
  output logic              halted
);

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_OUT  = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JC   = 3'b101;
  localparam logic [2:0] OP_JZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [PC_W-1:0]   pc_reg, pc_next, pc_inc;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic [DATA_W-1:0] o_reg, o_next;
  logic              carry_reg, carry_next;
  logic              zero_reg, zero_next;
  logic              out_valid_reg, out_valid_next;

  logic [2:0]        opc_field;
  logic              dst_field;
  logic [IMM_W-1:0]  imm_field;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W:0]   sum_full;
  logic [DATA_W:0]   diff_full;
  logic              exec;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  assign opc_field = imem_inst[INST_W-1 -: 3];
  assign dst_field = imem_inst[INST_W-4];
  assign imm_field = imem_inst[IMM_W-1:0];

  // Zero-extend the immediate to the datapath width bit by bit.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_imm_ext
      if (gi < IMM_W) begin : g_bit
        assign imm_ext[gi] = imm_field[gi];
      end else begin : g_pad
        assign imm_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // The extra MSB is carry-out for ADD and borrow for SUB.
  assign sum_full  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff_full = {1'b0, a_reg} - {1'b0, b_reg};
  assign pc_inc    = pc_reg + PC_W'(1);

`ifdef PARAM_CORE_HALT_EN
  typedef enum logic {ST_RUN, ST_HALT} state_t;
  state_t state_reg, state_next;

  assign exec   = run && (state_reg == ST_RUN);
  assign halted = (state_reg == ST_HALT);
`else
  assign exec   = run;
  assign halted = 1'b0;
`endif

  always_comb begin
    pc_next        = pc_reg;
    carry_next     = carry_reg;
    zero_next      = zero_reg;
    o_next         = o_reg;
    out_valid_next = 1'b0;
    wr_en          = 1'b0;
    wr_data        = '0;
`ifdef PARAM_CORE_HALT_EN
    state_next     = state_reg;
`endif
    if (exec) begin
      pc_next = pc_inc;
      case (opc_field)
        OP_MOVI: begin
          wr_en   = 1'b1;
          wr_data = imm_ext;
        end
        OP_ADD: begin
          wr_en      = 1'b1;
          wr_data    = sum_full[DATA_W-1:0];
          carry_next = sum_full[DATA_W];
          zero_next  = (sum_full[DATA_W-1:0] == '0);
        end
        OP_SUB: begin
          wr_en      = 1'b1;
          wr_data    = diff_full[DATA_W-1:0];
          carry_next = diff_full[DATA_W];
          zero_next  = (diff_full[DATA_W-1:0] == '0);
        end
        OP_OUT: begin
          o_next         = a_reg;
          out_valid_next = 1'b1;
        end
        OP_JMP: pc_next = imm_field[PC_W-1:0];
        OP_JC:  if (carry_reg) pc_next = imm_field[PC_W-1:0];
        OP_JZ:  if (zero_reg)  pc_next = imm_field[PC_W-1:0];
        OP_HALT: begin
`ifdef PARAM_CORE_HALT_EN
          pc_next    = pc_reg;
          state_next = ST_HALT;
`endif
        end
        default: ;
      endcase
    end
    a_next = (wr_en && !dst_field) ? wr_data : a_reg;
    b_next = (wr_en &&  dst_field) ? wr_data : b_reg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      o_reg         <= '0;
      carry_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      o_reg         <= o_next;
      carry_reg     <= carry_next;
      zero_reg      <= zero_next;
      out_valid_reg <= out_valid_next;
    end
  end

`ifdef PARAM_CORE_HALT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end
`endif

  assign imem_addr = pc_reg;
  assign out_o     = o_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_param_core.sv
// Directed-vector bench for param_core at default parameters; instruction memory is a
// combinational array the bench rewrites between steps. Honours PARAM_CORE_HALT_EN.
module tb_param_core;

  logic       clk;
  logic       resetn;
  logic       run;
  logic [3:0] imem_addr;
  logic [7:0] imem_inst;
  logic [3:0] out_o;
  logic       out_valid;
  logic       halted;

  logic [7:0] imem [16];

  int errors = 0;
  int checks = 0;

  param_core dut (
    .clk       (clk),
    .resetn    (resetn),
    .run       (run),
    .imem_addr (imem_addr),
    .imem_inst (imem_inst),
    .out_o     (out_o),
    .out_valid (out_valid),
    .halted    (halted)
  );

  assign imem_inst = imem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] w);
    for (int i = 0; i < 16; i++) imem[i] = w;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    run    = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    fill(8'h10);

    // Reset state; run low during reset must not matter.
    step();
    step();
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_out", 32'(out_o), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // MOVI A,5; MOVI B,3; ADD A; OUT; JC 0; JZ 0
    fill(8'h10);
    imem[0] = 8'h05; imem[1] = 8'h13; imem[2] = 8'h20;
    imem[3] = 8'h60; imem[4] = 8'hA0; imem[5] = 8'hC0;
    resetn = 1'b1;
    run    = 1'b1;
    step(); step(); step();
    check("t1_valid_before_out", 32'(out_valid), 32'd0);
    check("t1_pc3", 32'(imem_addr), 32'd3);
    step();
    check("t1_out", 32'(out_o), 32'd8);
    check("t1_valid", 32'(out_valid), 32'd1);
    step();
    check("t1_valid_drop", 32'(out_valid), 32'd0);
    check("t1_jc_nc", 32'(imem_addr), 32'd5);
    step();
    check("t1_jz_nz", 32'(imem_addr), 32'd6);

    // MOVI A,9; MOVI B,9; ADD A (A=2, carry=1); JC 0
    fill(8'h10);
    imem[0] = 8'h09; imem[1] = 8'h19; imem[2] = 8'h20; imem[3] = 8'hA0;
    do_reset();
    step(); step(); step(); step();
    check("t2_jc_taken", 32'(imem_addr), 32'd0);
    imem[0] = 8'h60;
    step();
    check("t2_sum_wrap", 32'(out_o), 32'd2);
    check("t2_valid", 32'(out_valid), 32'd1);
    // Reset mid-program clears O and the pulse.
    do_reset();
    check("t2_rst_out", 32'(out_o), 32'd0);
    check("t2_rst_valid", 32'(out_valid), 32'd0);
    check("t2_rst_pc", 32'(imem_addr), 32'd0);

    // MOVI A,3; MOVI B,3; SUB A (zero=1); JC 7; JZ 9; then borrow path.
    fill(8'h10);
    imem[0]  = 8'h03; imem[1]  = 8'h13; imem[2]  = 8'h40;
    imem[3]  = 8'hA7; imem[4]  = 8'hC9; imem[9]  = 8'h60;
    imem[10] = 8'h15; imem[11] = 8'h50; imem[12] = 8'hAE;
    imem[14] = 8'hC0; imem[15] = 8'h20;
    do_reset();
    step(); step(); step(); step();
    check("t3_jc_fall", 32'(imem_addr), 32'd4);
    step();
    check("t3_jz_taken", 32'(imem_addr), 32'd9);
    step();
    check("t3_sub_zero_out", 32'(out_o), 32'd0);
    check("t3_valid", 32'(out_valid), 32'd1);
    step(); step(); step();
    check("t3_jc_borrow", 32'(imem_addr), 32'd14);
    step();
    check("t3_jz_nz", 32'(imem_addr), 32'd15);
    step();
    check("t3_pc_wrap", 32'(imem_addr), 32'd0);
    imem[0] = 8'h60;
    step();
    check("t3_sub_b_then_add", 32'(out_o), 32'd11);

    // 16 MOVIs: pc walks to 15 and wraps to 0.
    for (int i = 0; i < 16; i++) imem[i] = 8'(i);
    do_reset();
    for (int i = 0; i < 15; i++) step();
    check("t4_pc15", 32'(imem_addr), 32'd15);
    step();
    check("t4_pc_wrap", 32'(imem_addr), 32'd0);
    imem[0] = 8'h06; imem[1] = 8'h60; imem[2] = 8'h09;
    step();
    step();
    run = 1'b0;
    check("t4_pending_valid", 32'(out_valid), 32'd1);
    check("t4_out", 32'(out_o), 32'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_stall_pc", 32'(imem_addr), 32'd2);
      check("t4_stall_valid", 32'(out_valid), 32'd0);
    end
    imem[2] = 8'h60;
    run = 1'b1;
    step();
    check("t4_a_frozen", 32'(out_o), 32'd6);
    check("t4_resume_pc", 32'(imem_addr), 32'd3);

    // MOVI A,1; MOVI B,2; HALT; OUT
    fill(8'h10);
    imem[0] = 8'h01; imem[1] = 8'h12; imem[2] = 8'hE0; imem[3] = 8'h60;
    do_reset();
    step(); step();
    check("t5_pc2", 32'(imem_addr), 32'd2);
    step();
`ifdef PARAM_CORE_HALT_EN
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_pc_hold", 32'(imem_addr), 32'd2);
    step(); step();
    check("t5_pc_hold2", 32'(imem_addr), 32'd2);
    check("t5_no_valid", 32'(out_valid), 32'd0);
    do_reset();
    check("t5_rst_pc", 32'(imem_addr), 32'd0);
    check("t5_rst_halted", 32'(halted), 32'd0);
`else
    check("t5_nop_pc", 32'(imem_addr), 32'd3);
    check("t5_halted_tied", 32'(halted), 32'd0);
    step();
    check("t5_out_after_nop", 32'(out_o), 32'd1);
    check("t5_valid", 32'(out_valid), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
